// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: generic pipeline stage register with a valid/ready handshake.
//   SKID=1: two entries (main + skid), registered in_ready, full throughput.
//   SKID=0: one entry, combinational ready pass-through.
// Ports:
//   clk, reset (async active-low), flush (sync, discards all entries)
//   in_valid/in_ready/in_data   upstream handshake + payload
//   out_valid/out_ready/out_data downstream handshake + payload (NOP_VALUE when idle)
//   occupancy                   held entries (0..2)
module pipe_stage_buffer #(
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = '0,
  parameter bit                    SKID       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  // state encoding doubles as the occupancy count
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  accept, pop;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_valid ? main_q : NOP_VALUE;
  assign occupancy = state_q;

  // flush forces ready high so upstream never stalls on a cycle whose payload is dropped anyway
  generate
    if (SKID) begin : g_skid
      assign in_ready = (state_q != FULL) || flush;
    end else begin : g_pass
      assign in_ready = !out_valid || out_ready || flush;
    end
  endgenerate

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept && SKID) begin
            // downstream stalled: park the new payload behind main
            skid_d  = in_data;
            state_d = FULL;
          end else if (pop) begin
            main_d  = NOP_VALUE;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: one SKID=1 and one SKID=0 instance share stimulus;
// each has a queue scoreboard of expected held payloads.
module tb_pipe_stage_buffer;
  localparam int          DW  = 64;
  localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  logic          ir1, ov1, ir0, ov0;
  logic [DW-1:0] od1, od0;
  logic [1:0]    occ1, occ0;

  int tests = 0;
  int fails = 0;
  logic acc1_last;
  logic [63:0] q1[$];
  logic [63:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_buffer #(.DATA_WIDTH(DW), .NOP_VALUE(NOP), .SKID(1'b1)) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(occ1));

  pipe_stage_buffer #(.DATA_WIDTH(DW), .NOP_VALUE(NOP), .SKID(1'b0)) u_pass (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .occupancy(occ0));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // check outputs mid-cycle against the scoreboards, then advance one edge
  task automatic cyc();
    logic e_ir1, e_ir0, acc1, acc0, pop1, pop0;
    #3;
    e_ir1 = !reset || flush || (q1.size() < 2);
    e_ir0 = !reset || flush || (q0.size() == 0) || out_ready;
    chk("s1_valid", ov1, 64'(q1.size() != 0));
    chk("s1_data",  od1, (q1.size() != 0) ? q1[0] : NOP);
    chk("s1_occ",   occ1, 64'(q1.size()));
    chk("s1_ready", ir1, e_ir1);
    chk("s0_valid", ov0, 64'(q0.size() != 0));
    chk("s0_data",  od0, (q0.size() != 0) ? q0[0] : NOP);
    chk("s0_occ",   occ0, 64'(q0.size()));
    chk("s0_ready", ir0, e_ir0);
    acc1 = reset && in_valid && e_ir1;
    acc0 = reset && in_valid && e_ir0;
    pop1 = (q1.size() != 0) && out_ready;
    pop0 = (q0.size() != 0) && out_ready;
    acc1_last = acc1;
    @(posedge clk);
    if (!reset || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (pop1) void'(q1.pop_front());
      if (acc1) q1.push_back(in_data);
      if (pop0) void'(q0.pop_front());
      if (acc0) q0.push_back(in_data);
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    // reset held with a payload offered
    in_valid = 1'b1; in_data = 64'hA5; out_ready = 1'b1;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("rst_first_data", od1, 64'hA5);
    cyc(); cyc();

    // streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 64'(i);
      cyc();
    end
    in_valid = 1'b0;
    cyc(); cyc();

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 64'h10; cyc();
    in_data = 64'h11; cyc();
    in_data = 64'h12; cyc();
    chk("bp_occ_full", occ1, 64'd2);
    chk("bp_ready_low", ir1, 1'b0);
    cyc();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (acc1_last) break;
    end
    in_valid = 1'b0;
    cyc(); cyc(); cyc(); cyc();

    // flush while FULL, payload offered in the flush cycle
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 64'h20; cyc();
    in_data = 64'h21; cyc();
    chk("fl_pre_occ", occ1, 64'd2);
    flush = 1'b1; in_data = 64'h33;
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_occ", occ1, 64'd0);
    chk("fl_data", od1, NOP);
    chk("fl_valid", ov1, 1'b0);
    cyc(); cyc();

    // toggling out_ready with a continuous stream
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 64'h40 + 64'(i);
      out_ready = i[0];
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc(); cyc();

    // asynchronous reset mid-FULL
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 64'h50; cyc();
    in_data = 64'h51; cyc();
    in_valid = 1'b0;
    chk("ar_pre_occ", occ1, 64'd2);
    #2 reset = 1'b0;
    #1;
    chk("ar_s1_valid", ov1, 1'b0);
    chk("ar_s1_data", od1, NOP);
    chk("ar_s1_occ", occ1, 64'd0);
    chk("ar_s1_ready", ir1, 1'b1);
    chk("ar_s0_valid", ov0, 1'b0);
    chk("ar_s0_data", od0, NOP);
    q1.delete(); q0.delete();
    @(posedge clk); #1;
    reset = 1'b1; out_ready = 1'b1;
    cyc(); cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
